// File: rtl/fp_operand_issue_if.sv
// Operand-issue bus: request side (in_*) and issued-operation side (out_*).
//
// Handshake rule for both sides: a transfer happens on a rising clk edge
// where valid & ready are both 1. A source that raises valid keeps the
// payload stable and valid asserted until that transfer. Ready may change
// freely and never depends combinationally on valid.
interface fp_operand_issue_if #(
    parameter int DEPTH = 4
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_op;
    logic [31:0]                  in_a;
    logic [31:0]                  in_b;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_op;
    logic [31:0]                  out_a;
    logic [31:0]                  out_b;
    logic                         out_special;
    logic [31:0]                  out_special_res;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Producer of requests / consumer of issued operations.
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b,
               out_special, out_special_res, count
    );

    // The issue stage itself.
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b,
               out_special, out_special_res, count
    );
endinterface

// File: rtl/fp_operand_issue.sv
// Issue stage in front of the single-precision add/mul units.
// Buffers operand pairs in a FIFO. At pop it orders add operands so that
// |A| >= |B| and resolves zero/denormal/Inf/NaN cases into a ready-made
// result. The outcome lands in a registered output stage.
module fp_operand_issue #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    fp_operand_issue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   occupancy;

    logic            push;
    logic            pop;
    entry_t          head;

    logic            valid_q;
    logic            op_q;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic            special_q;
    logic [31:0]     res_q;

    // Only full blocks a push; a same-cycle pop does not free the slot early.
    assign bus.in_ready = (occupancy < CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = (occupancy != '0) & (~valid_q | bus.out_ready);
    assign head         = mem[rd_ptr];

    assign bus.count           = occupancy;
    assign bus.out_valid       = valid_q;
    assign bus.out_op          = op_q;
    assign bus.out_a           = a_q;
    assign bus.out_b           = b_q;
    assign bus.out_special     = special_q;
    assign bus.out_special_res = res_q;

    // Ordering, classification and special-case resolution of the FIFO head.
    logic        swap;
    logic [31:0] nxt_a;
    logic [31:0] nxt_b;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        nxt_special;
    logic [31:0] nxt_res;
    logic        prod_sign;

    always_comb begin
        swap   = ~head.op & (head.b[30:0] > head.a[30:0]);
        nxt_a  = swap ? head.b : head.a;
        nxt_b  = swap ? head.a : head.b;

        // Denormals count as zero; the sign bit is kept as-is.
        a_zero = (nxt_a[30:23] == 8'd0);
        a_inf  = (nxt_a[30:23] == 8'hFF) & (nxt_a[22:0] == 23'd0);
        a_nan  = (nxt_a[30:23] == 8'hFF) & (nxt_a[22:0] != 23'd0);
        b_zero = (nxt_b[30:23] == 8'd0);
        b_inf  = (nxt_b[30:23] == 8'hFF) & (nxt_b[22:0] == 23'd0);
        b_nan  = (nxt_b[30:23] == 8'hFF) & (nxt_b[22:0] != 23'd0);

        prod_sign   = nxt_a[31] ^ nxt_b[31];
        nxt_special = 1'b1;
        nxt_res     = 32'd0;

        if (!head.op) begin
            if (a_nan | b_nan | (a_inf & b_inf & (nxt_a[31] != nxt_b[31]))) begin
                nxt_res = QNAN;
            end else if (a_inf) begin
                nxt_res = nxt_a;
            end else if (b_inf) begin
                nxt_res = nxt_b;
            end else if (a_zero & b_zero) begin
                nxt_res = {nxt_a[31] & nxt_b[31], 31'd0};
            end else if (a_zero) begin
                nxt_res = nxt_b;
            end else if (b_zero) begin
                nxt_res = nxt_a;
            end else begin
                nxt_special = 1'b0;
            end
        end else begin
            if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
                nxt_res = QNAN;
            end else if (a_inf | b_inf) begin
                nxt_res = {prod_sign, 8'hFF, 23'd0};
            end else if (a_zero | b_zero) begin
                nxt_res = {prod_sign, 31'd0};
            end else begin
                nxt_special = 1'b0;
            end
        end
    end

    // FIFO storage write; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CW'(1);
                2'b01:   occupancy <= occupancy - CW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Output register: load on pop, hold while stalled, drop valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op_q      <= 1'b0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            special_q <= 1'b0;
            res_q     <= 32'd0;
        end else if (pop) begin
            valid_q   <= 1'b1;
            op_q      <= head.op;
            a_q       <= nxt_a;
            b_q       <= nxt_b;
            special_q <= nxt_special;
            res_q     <= nxt_res;
        end else if (bus.out_ready) begin
            valid_q   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_operand_issue.sv
// Bench for fp_operand_issue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference of the issue stage.
module tb_fp_operand_issue;
    localparam int DEPTH = 4;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sp;
        logic [31:0] res;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_operand_issue_if #(.DEPTH(DEPTH)) bus ();

    fp_operand_issue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: queued requests {op,a,b} and the expected output register.
    logic [64:0] exp_q[$];
    logic        model_ov;
    exp_t        model_out;

    function automatic logic is_zero(input logic [31:0] v);
        return v[30:23] == 8'd0;
    endfunction
    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction
    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Expected issued operation for a request, straight from the rules.
    function automatic exp_t resolve(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [31:0] x;
        logic [31:0] y;
        logic        s;
        x = a;
        y = b;
        if (!op && ((b & 32'h7FFF_FFFF) > (a & 32'h7FFF_FFFF))) begin
            x = b;
            y = a;
        end
        r.op = op; r.a = x; r.b = y; r.sp = 1'b1; r.res = 32'd0;
        s = x[31] ^ y[31];
        if (!op) begin
            if (is_nan(x) || is_nan(y) || (is_inf(x) && is_inf(y) && x[31] != y[31])) r.res = QNAN;
            else if (is_inf(x))                 r.res = x;
            else if (is_inf(y))                 r.res = y;
            else if (is_zero(x) && is_zero(y))  r.res = (x[31] && y[31]) ? 32'h8000_0000 : 32'd0;
            else if (is_zero(x))                r.res = y;
            else if (is_zero(y))                r.res = x;
            else                                r.sp  = 1'b0;
        end else begin
            if (is_nan(x) || is_nan(y) || (is_zero(x) && is_inf(y)) || (is_inf(x) && is_zero(y)))
                r.res = QNAN;
            else if (is_inf(x) || is_inf(y))    r.res = s ? 32'hFF80_0000 : 32'h7F80_0000;
            else if (is_zero(x) || is_zero(y))  r.res = s ? 32'h8000_0000 : 32'd0;
            else                                r.sp  = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 4))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            default: e = 8'($urandom_range(1, 254));
        endcase
        m = ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the visible DUT state against the reference after an edge.
    task automatic check_outputs();
        chk("out_valid", 32'(bus.out_valid), 32'(model_ov));
        chk("count", 32'(bus.count), 32'(exp_q.size()));
        chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
        if (model_ov) begin
            chk("out_op", 32'(bus.out_op), 32'(model_out.op));
            chk("out_a", bus.out_a, model_out.a);
            chk("out_b", bus.out_b, model_out.b);
            chk("out_special", 32'(bus.out_special), 32'(model_out.sp));
            chk("out_special_res", bus.out_special_res, model_out.res);
        end
    endtask

    // One clock cycle of driving: inputs set after the falling edge, reference
    // advanced for the coming rising edge, outputs checked on the next falling edge.
    task automatic cycle(input logic v, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic rdy);
        logic        accept;
        logic        take;
        logic [64:0] head;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = rdy;
        #1;
        chk("in_ready_pre", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
        accept = v && (exp_q.size() < DEPTH);
        take   = (exp_q.size() > 0) && (!model_ov || rdy);
        if (take) begin
            head      = exp_q.pop_front();
            model_out = resolve(head[64], head[63:32], head[31:0]);
            model_ov  = 1'b1;
        end else if (rdy) begin
            model_ov  = 1'b0;
        end
        if (accept) exp_q.push_back({op, a, b});
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        model_ov = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_op", 32'(bus.out_op), 32'd0);
        chk("rst_out_a", bus.out_a, 32'd0);
        chk("rst_out_b", bus.out_b, 32'd0);
        chk("rst_out_special", 32'(bus.out_special), 32'd0);
        chk("rst_out_special_res", bus.out_special_res, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_ov = 1'b0;
        rst      = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        apply_reset();

        // Plain add, no swap: visible one cycle after acceptance.
        cycle(1'b1, 1'b0, 32'h4000_0000, 32'h3F80_0000, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_a", bus.out_a, 32'h4000_0000);
        chk("t1_special", 32'(bus.out_special), 32'd0);
        idle(1);

        // Add swaps on magnitude; multiply keeps order.
        cycle(1'b1, 1'b0, 32'h3F80_0000, 32'h4040_0000, 1'b1);
        cycle(1'b1, 1'b1, 32'h3F80_0000, 32'h4040_0000, 1'b1);
        chk("t2_add_a", bus.out_a, 32'h4040_0000);
        chk("t2_add_b", bus.out_b, 32'h3F80_0000);
        idle(1);
        chk("t2_mul_a", bus.out_a, 32'h3F80_0000);
        idle(1);

        // Special cases.
        cycle(1'b1, 1'b0, 32'h7F80_0000, 32'hFF80_0000, 1'b1);
        cycle(1'b1, 1'b1, 32'h0000_0000, 32'hFF80_0000, 1'b1);
        chk("t3_inf_minus_inf", bus.out_special_res, QNAN);
        cycle(1'b1, 1'b1, 32'h8000_0000, 32'h4000_0000, 1'b1);
        chk("t3_zero_times_inf", bus.out_special_res, QNAN);
        idle(1);
        chk("t3_neg_zero_product", bus.out_special_res, 32'h8000_0000);
        idle(1);

        // Back-pressure: six pushes while stalled, the sixth is refused.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 1'(i & 1), 32'h3F80_0000 + 32'(i << 20), 32'h4000_0000, 1'b0);
        chk("t4_count_full", 32'(bus.count), 32'd4);
        chk("t4_in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("t4_head_held", bus.out_b, 32'h3F80_0000);
        idle(6);

        // Streaming: one per cycle, occupancy settles and pointers wrap.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 1'($urandom), rand_fp(), rand_fp(), 1'b1);
        chk("t5_count_steady", 32'(bus.count), 32'd1);
        idle(3);

        // Reset with three queued entries and a valid output.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, rand_fp(), rand_fp(), 1'b0);
        chk("t6_count_pre", 32'(bus.count), 32'd3);
        chk("t6_valid_pre", 32'(bus.out_valid), 32'd1);
        apply_reset();
        idle(1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), rand_fp(), rand_fp(),
                  1'($urandom_range(0, 2) != 0));
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
